// File: rtl/procesador_frames_cfg.sv
`default_nettype none
// ============================================================================
// Module      : procesador_frames_cfg
// Description : Frame-synchronous Avalon-MM configuration register bank.
//               N_CH channel registers live in a shadow bank that the host
//               can rewrite at any time. A commit request arms a transfer
//               that copies the whole shadow bank into the active bank on
//               the next frame_sync pulse, so every channel changes together
//               and never mid-frame.
//
// Ports       : clk         system clock
//               reset       synchronous, active-high reset
//               address     Avalon word address (ADDR_W bits)
//               chipselect  Avalon slave select
//               write_n     active-low write strobe
//               read_n      active-low read strobe
//               writedata   32-bit write data
//               readdata    32-bit registered read data, latency 1
//               frame_sync  one-cycle frame boundary pulse
//               out_port    active bank, packed, ch0 in [DATA_W-1:0]
//               pending     high while a commit waits for frame_sync
//               irq         level interrupt (only with PROC_FRAMES_IRQ_EN)
//
// Address map : 0..N_CH-1  shadow channel k (R/W)
//               N_CH       CTRL/STATUS
//                            wr bit0 request commit, bit1 abort,
//                            bit2 irq_en (R/W), bit3 clear irq_flag
//                            rd {28'b0, irq_flag, irq_en, 1'b0, pending}
//               N_CH+1     COMMIT_CNT (RO, 32-bit, wrapping)
//               others     read 0, writes ignored
//
// Config      : PROC_FRAMES_IRQ_EN - when defined, adds irq_en, irq_flag
//               and the irq output. When undefined, CTRL bits 2/3 read 0
//               and writes to them are ignored.
//
// Parameters  : DATA_W 1..32, N_CH 1..8, ADDR_W with 2**ADDR_W >= N_CH+2,
//               RESET_VAL reset value of every channel register.
//
// Revision    : 1.0 - initial release
// ============================================================================
module procesador_frames_cfg #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned N_CH      = 4,
  parameter int unsigned ADDR_W    = 4,
  parameter int unsigned RESET_VAL = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [ADDR_W-1:0]      address,
  input  logic                   chipselect,
  input  logic                   write_n,
  input  logic                   read_n,
  input  logic [31:0]            writedata,
  output logic [31:0]            readdata,
  input  logic                   frame_sync,
  output logic [N_CH*DATA_W-1:0] out_port,
  output logic                   pending
`ifdef PROC_FRAMES_IRQ_EN
  ,
  output logic                   irq
`endif
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [DATA_W-1:0] c_reset_val = DATA_W'(RESET_VAL);
  localparam logic [ADDR_W-1:0] c_addr_ctrl = ADDR_W'(N_CH);
  localparam logic [ADDR_W-1:0] c_addr_cnt  = ADDR_W'(N_CH + 1);

  localparam logic [0:0] c_st_idle    = 1'b0;
  localparam logic [0:0] c_st_pending = 1'b1;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic [DATA_W-1:0] shadow_q [N_CH];
  logic [DATA_W-1:0] shadow_d [N_CH];
  logic [DATA_W-1:0] active_q [N_CH];
  logic [DATA_W-1:0] active_d [N_CH];
  logic [0:0]        state_q;
  logic [0:0]        state_d;
  logic [31:0]       commit_cnt_q;
  logic [31:0]       commit_cnt_d;
  logic [31:0]       readdata_q;
  logic [31:0]       readdata_d;

`ifdef PROC_FRAMES_IRQ_EN
  logic              irq_en_q;
  logic              irq_en_d;
  logic              irq_flag_q;
  logic              irq_flag_d;
`endif

  // --------------------------------------------------------------------------
  // Bus decode
  // --------------------------------------------------------------------------
  logic        w_wr;
  logic        w_rd;
  logic        w_ctrl_wr;
  logic        w_req;
  logic        w_abort;
  logic        w_commit;
  logic [31:0] w_status;
  logic [31:0] w_rd_data;
  logic        w_unused;

  assign w_wr      = chipselect & ~write_n;
  assign w_rd      = chipselect & ~read_n;
  assign w_ctrl_wr = w_wr & (address == c_addr_ctrl);
  assign w_req     = w_ctrl_wr & writedata[0];
  assign w_abort   = w_ctrl_wr & writedata[1];

  // A commit happens only when armed; frame_sync in IDLE is a no-op. An
  // abort arriving together with frame_sync loses, the copy goes ahead.
  assign w_commit  = (state_q == c_st_pending) & frame_sync;

  // Upper writedata bits beyond DATA_W (and CTRL bits 2/3 without the
  // interrupt option) are intentionally ignored.
  assign w_unused  = ^writedata;

  // --------------------------------------------------------------------------
  // Commit state machine
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_st_idle: begin
        // Request and abort in the same write: abort wins, stay idle.
        if (w_req && !w_abort) begin
          state_d = c_st_pending;
        end
      end
      c_st_pending: begin
        // Further requests while armed are ignored (no double commit).
        if (frame_sync || w_abort) begin
          state_d = c_st_idle;
        end
      end
      default: state_d = c_st_idle;
    endcase
  end

  // --------------------------------------------------------------------------
  // Shadow and active banks
  // --------------------------------------------------------------------------
  // The copy reads shadow_q, so a shadow write landing on the commit edge is
  // not part of this commit; it waits for the next one.
  always_comb begin
    for (int k = 0; k < N_CH; k++) begin
      shadow_d[k] = shadow_q[k];
      active_d[k] = active_q[k];
      if (w_wr && (address == ADDR_W'(k))) begin
        shadow_d[k] = writedata[DATA_W-1:0];
      end
      if (w_commit) begin
        active_d[k] = shadow_q[k];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Commit counter and interrupt state
  // --------------------------------------------------------------------------
  always_comb begin
    commit_cnt_d = commit_cnt_q;
    if (w_commit) begin
      commit_cnt_d = commit_cnt_q + 32'd1;
    end
  end

`ifdef PROC_FRAMES_IRQ_EN
  always_comb begin
    irq_en_d   = irq_en_q;
    irq_flag_d = irq_flag_q;
    if (w_ctrl_wr) begin
      irq_en_d = writedata[2];
    end
    // Set has priority over a clear in the same cycle.
    if (w_commit) begin
      irq_flag_d = 1'b1;
    end else if (w_ctrl_wr && writedata[3]) begin
      irq_flag_d = 1'b0;
    end
  end

  assign w_status = {28'd0, irq_flag_q, irq_en_q, 1'b0, state_q == c_st_pending};
  assign irq      = irq_flag_q & irq_en_q;
`else
  assign w_status = {31'd0, state_q == c_st_pending};
`endif

  // --------------------------------------------------------------------------
  // Read path: registered, latency 1, holds between reads
  // --------------------------------------------------------------------------
  always_comb begin
    w_rd_data = 32'd0;
    for (int k = 0; k < N_CH; k++) begin
      if (address == ADDR_W'(k)) begin
        w_rd_data = 32'(shadow_q[k]);
      end
    end
    if (address == c_addr_ctrl) begin
      w_rd_data = w_status;
    end
    if (address == c_addr_cnt) begin
      w_rd_data = commit_cnt_q;
    end
  end

  always_comb begin
    readdata_d = readdata_q;
    if (w_rd) begin
      readdata_d = w_rd_data;
    end
  end

  // --------------------------------------------------------------------------
  // Sequential update
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < N_CH; k++) begin
        shadow_q[k] <= c_reset_val;
        active_q[k] <= c_reset_val;
      end
      state_q      <= c_st_idle;
      commit_cnt_q <= 32'd0;
      readdata_q   <= 32'd0;
`ifdef PROC_FRAMES_IRQ_EN
      irq_en_q     <= 1'b0;
      irq_flag_q   <= 1'b0;
`endif
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        shadow_q[k] <= shadow_d[k];
        active_q[k] <= active_d[k];
      end
      state_q      <= state_d;
      commit_cnt_q <= commit_cnt_d;
      readdata_q   <= readdata_d;
`ifdef PROC_FRAMES_IRQ_EN
      irq_en_q     <= irq_en_d;
      irq_flag_q   <= irq_flag_d;
`endif
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  generate
    for (genvar g = 0; g < N_CH; g++) begin : g_out_pack
      assign out_port[g*DATA_W +: DATA_W] = active_q[g];
    end
  endgenerate

  assign pending  = (state_q == c_st_pending);
  assign readdata = readdata_q;

endmodule
`default_nettype wire

// File: doc/procesador_frames_cfg.md
# procesador_frames_cfg

Parametrised Avalon-MM configuration register bank for the frame processing pipeline. It holds N_CH channel registers, for example integration frame counts or per-channel gains, in a shadow bank writable by the Nios at any time. A commit copies the whole shadow bank into the active bank, but only on a `frame_sync` pulse from the pipeline, so no channel changes mid-frame and all channels change together. It generalises the single 8-bit output PIO to multi-channel, width-parametrised, frame-synchronous operation with status, commit counting and an optional interrupt.

## Interface
- DATA_W, 8: channel register width, 1..32.
- N_CH, 4: number of channels, 1..8.
- ADDR_W, 4: Avalon word-address width; must satisfy 2^ADDR_W ≥ N_CH+2.
- RESET_VAL, 1: reset value of every shadow and active channel register.
- clk  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- address  in  ADDR_W  Avalon word address.
- chipselect  in  1  Avalon slave select.
- write_n  in  1  active-low write strobe.
- read_n  in  1  active-low read strobe.
- writedata  in  32  write data.
- readdata  out  32  read data, registered, read latency 1.
- frame_sync  in  1  one-cycle pulse from the pipeline at each frame boundary.
- out_port  out  N_CH*DATA_W  active bank, packed; ch0 occupies bits [DATA_W-1:0].
- pending  out  1  high while a commit is waiting for `frame_sync`.
- irq  out  1  level interrupt; present only with PROC_FRAMES_IRQ_EN.

## Operation
- Address map:
  - 0..N_CH-1: shadow channel k, R/W. Writes take `writedata[DATA_W-1:0]`; reads return the shadow value, zero-extended.
  - N_CH: CTRL/STATUS.
    - Write bit0=1 requests a commit.
    - Write bit1=1 aborts a pending commit.
    - Bit2 is irq_en, R/W.
    - Write bit3=1 clears irq_flag.
    - Read returns {28'b0, irq_flag, irq_en, 0, pending}.
  - N_CH+1: COMMIT_CNT, RO, 32-bit count of completed commits, wraps 0xFFFFFFFF→0.
  - Other addresses read 0; writes to them are ignored.
- State machine IDLE/PENDING:
  - IDLE→PENDING on a commit-request write.
  - PENDING→IDLE on `frame_sync`: the active bank is loaded from the shadow bank, COMMIT_CNT increments, irq_flag is set.
  - PENDING→IDLE on an abort write; active bank, COMMIT_CNT and irq_flag are unchanged.
  - `frame_sync` in IDLE has no effect.
- Simultaneous events:
  - Shadow write and commit copy in the same cycle: the copy uses the pre-write shadow value. The new value waits for the next commit.
  - Commit request in the same cycle as `frame_sync` while IDLE: the block enters PENDING and commits on the next `frame_sync`.
  - Commit request while PENDING: ignored, no double count.
  - Request and abort bits both set in one write: abort wins; the state becomes IDLE.
  - Abort in the same cycle as `frame_sync` while PENDING: the commit completes; abort is ignored.
  - irq_flag set and clear in the same cycle: set wins.
- irq = irq_flag & irq_en.

## Timing
- All registers update on posedge clk.
- Reset values:
  - Shadow and active banks = RESET_VAL.
  - State IDLE; `pending`=0.
  - COMMIT_CNT=0; irq_en=0; irq_flag=0; irq=0.
  - readdata=0.
- Reset asserted mid-PENDING discards the commit; `out_port` returns to RESET_VAL on the next edge.
- A write at edge N is visible in a shadow/CTRL read issued at N+1.
- readdata is valid one cycle after the read strobe and holds otherwise.
- `pending` rises in the cycle after the request write.
- On `frame_sync` at edge F:
  - `out_port`, COMMIT_CNT and irq_flag update at F.
  - `pending` falls at F.
  - irq rises at F if irq_en.
- Commit latency is unbounded; it is set by the `frame_sync` period.

## Configuration
- PROC_FRAMES_IRQ_EN defined: irq_flag, irq_en and the `irq` port exist as specified.
- PROC_FRAMES_IRQ_EN undefined: the `irq` port is absent; CTRL bits 2 and 3 read 0 and writes to them are ignored. All other behaviour is identical.

## Test plan
- Reset values: after reset, `out_port`=each channel 1 (RESET_VAL), all CSR reads = 0 except shadow reads = 1, `pending`=0.
- Basic commit: write ch0=0x20 and ch3=0x05, write CTRL=1, then `frame_sync` after 10 cycles. `out_port` is unchanged until `frame_sync`, then shows ch0=0x20 and ch3=0x05 at that edge; COMMIT_CNT=1; `pending` 1→0.
- Write collision: while PENDING, write ch1=0x7F in the same cycle as `frame_sync`. Active ch1 keeps the prior shadow value; shadow reads 0x7F; the next commit applies 0x7F.
- Abort and duplicate request: request, request again, abort, then `frame_sync`. `out_port` is unchanged and COMMIT_CNT=0; a separate run with request+request then `frame_sync` gives COMMIT_CNT=1.
- IRQ (macro on): irq_en=1, commit completes → irq=1. Write CTRL bit3 → irq=0. Clear coinciding with a new commit completion leaves irq=1.
- Reset mid-operation and wrap: assert reset while PENDING → RESET_VAL restored and `pending`=0. Force COMMIT_CNT to 0xFFFFFFFF in the bench, commit once → reads 0.
